// File: rtl/bch_job_arbiter.sv
// bch_job_arbiter
// Shares one bch decoder core between NREQ requesters. A round-robin pick
// grants one requester per job; the job's code/mode are latched and pulsed
// into the core with core_set, the requester's 64-bit beats are streamed while
// core_ready is high, and the core's output words (core_finish window) are
// queued in a result FIFO tagged {id, err, last, odata}.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   req_valid/code/mode/data  per-requester job interface (data: 64 bits each)
//   req_grant                 one-hot grant, held from accept until job done
//   req_pop                   beat of the granted requester consumed this cycle
//   core_set/mode/code/idata  job start pulse, latched job fields, beat data
//   core_ready/finish/odata   core handshake and output word
//   res_valid/ready/data      result FIFO head, popped on valid & ready
//   busy                      FSM not idle
//   err_len/underflow/ovf     sticky error flags, cleared only by reset
//
// Optional build macro: BCH_ARB_TIMEOUT_EN adds a WAIT_FIN watchdog of
// TIMEOUT_CYC cycles that closes the job with an error result word.
module bch_job_arbiter #(
    parameter int NREQ        = 2,
    parameter int ID_W        = 1,
    parameter int RES_DEPTH   = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [2*NREQ-1:0]  req_code,
    input  logic [NREQ-1:0]    req_mode,
    input  logic [64*NREQ-1:0] req_data,
    output logic [NREQ-1:0]    req_grant,
    output logic [NREQ-1:0]    req_pop,
    output logic               core_set,
    output logic               core_mode,
    output logic [1:0]         core_code,
    output logic [63:0]        core_idata,
    input  logic               core_ready,
    input  logic               core_finish,
    input  logic [9:0]         core_odata,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ID_W+11:0]   res_data,
    output logic               busy,
    output logic               err_len,
    output logic               err_underflow,
    output logic               err_ovf
);

    localparam int RW = ID_W + 12;
    localparam int AW = $clog2(RES_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET,
        S_LOAD,
        S_WAIT_FIN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] rr_q;
    logic [ID_W-1:0] pick_id;
    logic            pick_vld;
    logic [1:0]      code_q;
    logic            mode_q;
    logic [7:0]      beat_cnt;
    logic [7:0]      beat_exp;
    logic [9:0]      skid_q;
    logic            granted;
    logic            pop_beat;
    logic            len_err;
    logic            push;
    logic [RW-1:0]   push_word;

    logic [RW-1:0]   fifo_mem [RES_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            fifo_full, fifo_empty, fifo_pop, fifo_wr;

`ifdef BCH_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]   tmo_cnt;
`endif

    // Round-robin pick: first requester with req_valid at or after rr_q.
    always_comb begin
        int unsigned j;
        j        = 0;
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(rr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!pick_vld && req_valid[j]) begin
                pick_vld = 1'b1;
                pick_id  = ID_W'(j);
            end
        end
    end

    // Code 0 selects the core's default length, same as code 3.
    always_comb begin
        case (code_q)
            2'd1:    beat_exp = 8'd8;
            2'd2:    beat_exp = 8'd32;
            default: beat_exp = 8'd128;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        core_set  = 1'b0;
        req_pop   = '0;
        pop_beat  = 1'b0;
        len_err   = 1'b0;
        push      = 1'b0;
        push_word = '0;
        granted   = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_vld) state_nx = S_SET;
            end
            S_SET: begin
                granted  = 1'b1;
                core_set = 1'b1;
                state_nx = S_LOAD;
            end
            S_LOAD: begin
                granted = 1'b1;
                if (core_ready) begin
                    // Beats stop at the expected count; extra demand is a length error.
                    if (beat_cnt < beat_exp) begin
                        pop_beat      = 1'b1;
                        req_pop[id_q] = 1'b1;
                    end else begin
                        len_err = 1'b1;
                    end
                end else if (beat_cnt != '0) begin
                    len_err  = (beat_cnt != beat_exp);
                    state_nx = S_WAIT_FIN;
                end
            end
            S_WAIT_FIN: begin
                granted = 1'b1;
                if (core_finish) begin
                    state_nx = S_DRAIN;
                end
`ifdef BCH_ARB_TIMEOUT_EN
                else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    push      = 1'b1;
                    push_word = {id_q, 1'b1, 1'b1, 10'd0};
                    state_nx  = S_DONE;
                end
`endif
            end
            S_DRAIN: begin
                // The skid register delays each word by one cycle so the final
                // word can be tagged last when the finish window closes.
                granted   = 1'b1;
                push      = 1'b1;
                push_word = {id_q, 1'b0, ~core_finish, skid_q};
                if (!core_finish) state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign req_grant  = granted ? (NREQ'(1) << id_q) : '0;
    assign core_idata = granted ? req_data[64*int'(id_q) +: 64] : '0;
    assign core_code  = code_q;
    assign core_mode  = mode_q;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_q          <= '0;
            rr_q          <= '0;
            code_q        <= '0;
            mode_q        <= 1'b0;
            beat_cnt      <= '0;
            skid_q        <= '0;
            err_len       <= 1'b0;
            err_underflow <= 1'b0;
            err_ovf       <= 1'b0;
        end else begin
            if (state == S_IDLE && pick_vld) begin
                id_q     <= pick_id;
                code_q   <= req_code[2*int'(pick_id) +: 2];
                mode_q   <= req_mode[pick_id];
                beat_cnt <= '0;
            end
            if (pop_beat) begin
                beat_cnt <= beat_cnt + 8'd1;
                if (!req_valid[id_q]) err_underflow <= 1'b1;
            end
            if (len_err) err_len <= 1'b1;
            if (core_finish && (state == S_WAIT_FIN || state == S_DRAIN)) begin
                skid_q <= core_odata;
            end
            if (state == S_DONE) begin
                if (int'(id_q) == NREQ - 1) rr_q <= '0;
                else                        rr_q <= id_q + 1'b1;
            end
            if (push && fifo_full && !fifo_pop) err_ovf <= 1'b1;
        end
    end

`ifdef BCH_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                   tmo_cnt <= '0;
        else if (state == S_WAIT_FIN) tmo_cnt <= tmo_cnt + 1'b1;
        else                         tmo_cnt <= '0;
    end
`endif

    // Result FIFO; a push into a full FIFO is accepted when a pop frees a slot
    // in the same cycle.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_pop   = res_ready && !fifo_empty;
    assign fifo_wr    = push && (!fifo_full || fifo_pop);
    assign res_valid  = !fifo_empty;
    assign res_data   = fifo_empty ? '0 : fifo_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr[AW-1:0]] <= push_word;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_wr)  wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule
